spi_slave_mode: RTL and testbench

- Next-generation SPI slave: parametrised word width, all four SPI modes (CPOL/CPHA), MSB/LSB-first.
- Synchronised chip-select, proper frame start/abort, buffered RX/TX words with valid/ready handshakes and overrun/underrun flags.
- Sits between an external SPI master pin group and the internal valid/ready bus fabric; oversampled by the system clock.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_slave_mode_if.sv | 25 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_mode.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave_mode.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the spi_slave_mode block.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

  localparam int unsigned MAX_DATA_SIZE = 32;
  localparam int unsigned IDX_W         = $clog2(MAX_DATA_SIZE);

  // Bit counter width able to hold the value data_size itself
  function automatic int unsigned cnt_width(input int unsigned data_size);
    return $clog2(data_size + 1);
  endfunction

  // First bit to appear on the wire for a word of the given width
  function automatic logic first_bit(input logic [MAX_DATA_SIZE-1:0] word,
                                     input int unsigned width,
                                     input logic msb_first);
    return msb_first ? word[IDX_W'(width - 32'd1)] : word[0];
  endfunction

endpackage

// File: rtl/spi_slave_mode_if.sv
// Fabric-side valid/ready bus and status of the SPI slave.
interface spi_slave_mode_if #(
  parameter int unsigned DATA_SIZE = 16
);
  logic [DATA_SIZE-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_SIZE-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;
  logic                 overrun;
  logic                 underrun;
  logic                 clr_err;

  modport slave (
    output rx_data, rx_valid, tx_ready, busy, overrun, underrun,
    input  rx_ready, tx_data, tx_valid, clr_err
  );

  modport master (
    input  rx_data, rx_valid, tx_ready, busy, overrun, underrun,
    output rx_ready, tx_data, tx_valid, clr_err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with rise/fall pulses from the last two samples.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Synchroniser chain plus one history stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_mode.sv
// SPI slave, all CPOL/CPHA modes, MSB/LSB-first, buffered RX/TX words.
// Optional: define SPI_SLAVE_MODE_LOOPBACK_EN to add the lpbk input, which
// reloads the shifter from the last received word instead of TX holding.
module spi_slave_mode
  import spi_pkg::*;
#(
  parameter int unsigned          DATA_SIZE   = 16,
  parameter bit                   CPOL        = 1'b0,
  parameter bit                   CPHA        = 1'b0,
  parameter bit                   MSB_FIRST   = 1'b1,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DATA_SIZE-1:0] TX_DEFAULT  = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
`ifdef SPI_SLAVE_MODE_LOOPBACK_EN
  input  logic lpbk,
`endif
  spi_slave_mode_if.slave bus
);

  localparam int unsigned CNT_W    = cnt_width(DATA_SIZE);
  localparam logic [1:0]  ST_IDLE  = IDLE;
  localparam logic [1:0]  ST_LOAD  = LOAD;
  localparam logic [1:0]  ST_SHIFT = SHIFT;

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_d(sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_d(cs_n),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_d(mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  // SHIFT exits on the cs_n level, so its rise pulse is not needed
  assign w_unused = &{1'b0, w_sclk_lvl, w_cs_rise, w_mosi_rise, w_mosi_fall};

  logic w_lead, w_trail, w_sample, w_shift;
  assign w_lead   = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_shift  = CPHA ? w_lead  : w_trail;

  logic                 w_lb;
`ifdef SPI_SLAVE_MODE_LOOPBACK_EN
  assign w_lb = lpbk;
`else
  assign w_lb = 1'b0;
`endif

  logic [1:0]           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_SIZE-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [DATA_SIZE-1:0] r_tx_sh, w_tx_sh_nxt;
  logic [DATA_SIZE-1:0] r_tx_hold, w_tx_hold_nxt;
  logic [DATA_SIZE-1:0] r_rx_data, w_rx_data_nxt;
  logic                 r_tx_ready, w_tx_ready_nxt;
  logic                 r_rx_valid, w_rx_valid_nxt;
  logic                 r_ovr, w_ovr_nxt;
  logic                 r_und, w_und_nxt;
  logic                 r_skip, w_skip_nxt;
  logic                 w_load, w_start, w_done, w_ovr_set, w_und_set;
  logic                 w_accept;

  assign w_accept = bus.tx_valid & r_tx_ready;

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rx_sh_nxt    = r_rx_sh;
    w_tx_sh_nxt    = r_tx_sh;
    w_tx_hold_nxt  = r_tx_hold;
    w_tx_ready_nxt = r_tx_ready;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = r_rx_valid;
    w_ovr_nxt      = r_ovr;
    w_und_nxt      = r_und;
    w_skip_nxt     = r_skip;
    w_load         = 1'b0;
    w_start        = 1'b0;
    w_done         = 1'b0;
    w_ovr_set      = 1'b0;
    w_und_set      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_start     = 1'b1;
        w_cnt_nxt   = '0;
        // CPHA=1: the first leading edge must not advance the pre-driven bit
        w_skip_nxt  = CPHA;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_cs_lvl) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(DATA_SIZE)) begin
          w_done     = 1'b1;
          w_load     = 1'b1;
          w_cnt_nxt  = '0;
          // The next shift edge belongs to the word just completed
          w_skip_nxt = 1'b1;
        end else begin
          if (w_sample) begin
            w_rx_sh_nxt = MSB_FIRST ? {r_rx_sh[DATA_SIZE-2:0], w_mosi}
                                    : {w_mosi, r_rx_sh[DATA_SIZE-1:1]};
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
          if (w_shift) begin
            if (r_skip) w_skip_nxt = 1'b0;
            else        w_tx_sh_nxt = MSB_FIRST ? {r_tx_sh[DATA_SIZE-2:0], 1'b0}
                                                : {1'b0, r_tx_sh[DATA_SIZE-1:1]};
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Completed word hand-off to the RX buffer
    if (w_done) begin
      w_rx_data_nxt  = r_rx_sh;
      w_rx_valid_nxt = 1'b1;
      w_ovr_set      = r_rx_valid & ~bus.rx_ready;
    end else if (r_rx_valid && bus.rx_ready) begin
      w_rx_valid_nxt = 1'b0;
    end

    // Shifter load from loopback, TX holding, or the default word
    if (w_load) begin
      if (w_lb) begin
        w_tx_sh_nxt = w_done ? r_rx_sh : r_rx_data;
      end else if (!r_tx_ready) begin
        w_tx_sh_nxt    = r_tx_hold;
        w_tx_ready_nxt = 1'b1;
      end else begin
        w_tx_sh_nxt = TX_DEFAULT;
        w_und_set   = w_start;
      end
    end

    if (w_accept) begin
      w_tx_hold_nxt  = bus.tx_data;
      w_tx_ready_nxt = 1'b0;
    end

    // Sticky flags: a same-cycle set wins over clear
    if (bus.clr_err) begin
      w_ovr_nxt = 1'b0;
      w_und_nxt = 1'b0;
    end
    if (w_ovr_set) w_ovr_nxt = 1'b1;
    if (w_und_set) w_und_nxt = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rx_sh    <= '0;
      r_tx_sh    <= TX_DEFAULT;
      r_tx_hold  <= '0;
      r_tx_ready <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
      r_und      <= 1'b0;
      r_skip     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_tx_hold  <= w_tx_hold_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_ovr      <= w_ovr_nxt;
      r_und      <= w_und_nxt;
      r_skip     <= w_skip_nxt;
    end
  end

  assign miso         = first_bit(32'(r_tx_sh), DATA_SIZE, MSB_FIRST);
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.tx_ready = r_tx_ready;
  assign bus.busy     = ~w_cs_lvl;
  assign bus.overrun  = r_ovr;
  assign bus.underrun = r_und;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Scoreboard bench: mode 0 / 16-bit MSB-first and mode 3 / 8-bit LSB-first.
module tb_spi_slave_mode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_sclk = 1'b0, a_cs_n = 1'b1, a_mosi = 1'b0, a_miso;
  logic b_sclk = 1'b1, b_cs_n = 1'b1, b_mosi = 1'b0, b_miso;

  spi_slave_mode_if #(.DATA_SIZE(16)) bus_a ();
  spi_slave_mode_if #(.DATA_SIZE(8))  bus_b ();

  spi_slave_mode #(
    .DATA_SIZE(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
    .SYNC_STAGES(2), .TX_DEFAULT(16'hFFFF)
  ) dut_a (
    .clk(clk), .rst(rst), .sclk(a_sclk), .cs_n(a_cs_n), .mosi(a_mosi), .miso(a_miso),
`ifdef SPI_SLAVE_MODE_LOOPBACK_EN
    .lpbk(1'b0),
`endif
    .bus(bus_a)
  );

  spi_slave_mode #(
    .DATA_SIZE(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0),
    .SYNC_STAGES(2), .TX_DEFAULT(8'h00)
  ) dut_b (
    .clk(clk), .rst(rst), .sclk(b_sclk), .cs_n(b_cs_n), .mosi(b_mosi), .miso(b_miso),
`ifdef SPI_SLAVE_MODE_LOOPBACK_EN
    .lpbk(1'b0),
`endif
    .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] qa[$];
  logic [7:0]  qb[$];
  logic [15:0] mi;
  logic [7:0]  mi8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Received words are scored when the fabric accepts them
  always @(negedge clk) begin
    if (!rst && bus_a.rx_valid === 1'b1 && bus_a.rx_ready === 1'b1) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rx_a_unexpected: got 0x%0h expected none", bus_a.rx_data);
      end else chk("rx_a", 32'(bus_a.rx_data), 32'(qa.pop_front()));
    end
    if (!rst && bus_b.rx_valid === 1'b1 && bus_b.rx_ready === 1'b1) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rx_b_unexpected: got 0x%0h expected none", bus_b.rx_data);
      end else chk("rx_b", 32'(bus_b.rx_data), 32'(qb.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx_a(input logic [15:0] d);
    chkb("tx_ready_a_empty", bus_a.tx_ready, 1'b1);
    bus_a.tx_data = d; bus_a.tx_valid = 1'b1;
    tick(1);
    bus_a.tx_valid = 1'b0;
    chkb("tx_ready_a_full", bus_a.tx_ready, 1'b0);
  endtask

  task automatic push_tx_b(input logic [7:0] d);
    bus_b.tx_data = d; bus_b.tx_valid = 1'b1;
    tick(1);
    bus_b.tx_valid = 1'b0;
    chkb("tx_ready_b_full", bus_b.tx_ready, 1'b0);
  endtask

  task automatic clr_pulse_a();
    bus_a.clr_err = 1'b1;
    tick(1);
    bus_a.clr_err = 1'b0;
    tick(1);
  endtask

  // Mode 0 master, MSB first, n bits of mo
  task automatic bits_a(input logic [15:0] mo_in, input int n, output logic [15:0] mi_o);
    logic [15:0] mo;
    mo = mo_in; mi_o = '0;
    for (int i = 0; i < n; i++) begin
      a_mosi = mo[15]; mo = mo << 1;
      #50 a_sclk = 1'b1;
      mi_o = {mi_o[14:0], a_miso};
      #50 a_sclk = 1'b0;
    end
  endtask

  // Mode 3 master, LSB first, 8 bits
  task automatic bits_b(input logic [7:0] mo_in, output logic [7:0] mi_o);
    logic [7:0] mo;
    mo = mo_in; mi_o = '0;
    for (int i = 0; i < 8; i++) begin
      b_sclk = 1'b0; b_mosi = mo[0]; mo = mo >> 1;
      #50 b_sclk = 1'b1;
      mi_o = {b_miso, mi_o[7:1]};
      #50;
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chkb({tag, "_rx_valid"}, bus_a.rx_valid, 1'b0);
    chkb({tag, "_tx_ready"}, bus_a.tx_ready, 1'b1);
    chkb({tag, "_busy"},     bus_a.busy,     1'b0);
    chkb({tag, "_overrun"},  bus_a.overrun,  1'b0);
    chkb({tag, "_underrun"}, bus_a.underrun, 1'b0);
    chkb({tag, "_miso"},     a_miso,         1'b1);
    chk ({tag, "_rx_data"},  32'(bus_a.rx_data), 32'h0);
  endtask

  initial begin
    bus_a.rx_ready = 1'b1; bus_a.tx_valid = 1'b0; bus_a.tx_data = '0; bus_a.clr_err = 1'b0;
    bus_b.rx_ready = 1'b1; bus_b.tx_valid = 1'b0; bus_b.tx_data = '0; bus_b.clr_err = 1'b0;
    rst = 1'b1;
    tick(3);
    chk_reset_a("rst_a");
    chkb("rst_b_miso", b_miso, 1'b0);
    chkb("rst_b_tx_ready", bus_b.tx_ready, 1'b1);
    chkb("rst_b_rx_valid", bus_b.rx_valid, 1'b0);
    rst = 1'b0;
    tick(3);

    // Mode 0, preloaded TX
    push_tx_a(16'h3C5A);
    a_cs_n = 1'b0; #100;
    chkb("t1_busy", bus_a.busy, 1'b1);
    qa.push_back(16'hA5C3);
    bits_a(16'hA5C3, 16, mi);
    chk("t1_miso", 32'(mi), 32'h3C5A);
    #100 a_cs_n = 1'b1; #100;
    chkb("t1_underrun", bus_a.underrun, 1'b0);
    chkb("t1_busy_end", bus_a.busy, 1'b0);
    chkb("t1_tx_ready", bus_a.tx_ready, 1'b1);
    chk("t1_rx_seen", 32'(qa.size()), 32'h0);

    // Mode 3, LSB first, 8-bit
    push_tx_b(8'h7E);
    b_cs_n = 1'b0; #100;
    qb.push_back(8'h81);
    bits_b(8'h81, mi8);
    chk("t2_miso", 32'(mi8), 32'h7E);
    #100 b_cs_n = 1'b1; #100;
    chkb("t2_underrun", bus_b.underrun, 1'b0);
    chk("t2_rx_seen", 32'(qb.size()), 32'h0);

    // Back-to-back words with the consumer stalled
    bus_a.rx_ready = 1'b0;
    push_tx_a(16'h1111);
    a_cs_n = 1'b0; #100;
    bits_a(16'h1357, 16, mi);
    chk("t3_miso_w1", 32'(mi), 32'h1111);
    bits_a(16'h2468, 16, mi);
    chk("t3_miso_w2", 32'(mi), 32'hFFFF);
    #100 a_cs_n = 1'b1; #100;
    chkb("t3_overrun", bus_a.overrun, 1'b1);
    chkb("t3_rx_valid", bus_a.rx_valid, 1'b1);
    qa.push_back(16'h2468);
    bus_a.rx_ready = 1'b1;
    tick(3);
    chk("t3_rx_seen", 32'(qa.size()), 32'h0);
    clr_pulse_a();
    chkb("t3_overrun_clr", bus_a.overrun, 1'b0);

    // No TX word loaded
    a_cs_n = 1'b0; #100;
    qa.push_back(16'h0F0F);
    bits_a(16'h0F0F, 16, mi);
    chk("t4_miso", 32'(mi), 32'hFFFF);
    #100 a_cs_n = 1'b1; #100;
    chkb("t4_underrun", bus_a.underrun, 1'b1);
    chk("t4_rx_seen", 32'(qa.size()), 32'h0);
    clr_pulse_a();
    chkb("t4_underrun_clr", bus_a.underrun, 1'b0);

    // Abort after 7 bits, then a clean frame
    push_tx_a(16'hAAAA);
    a_cs_n = 1'b0; #100;
    bits_a(16'h5555, 7, mi);
    #100 a_cs_n = 1'b1; #100;
    chkb("t5_rx_valid", bus_a.rx_valid, 1'b0);
    chkb("t5_busy", bus_a.busy, 1'b0);
    tick(1);
    push_tx_a(16'hC0DE);
    a_cs_n = 1'b0; #100;
    qa.push_back(16'h1234);
    bits_a(16'h1234, 16, mi);
    chk("t5_miso", 32'(mi), 32'hC0DE);
    #100 a_cs_n = 1'b1; #100;
    chk("t5_rx_seen", 32'(qa.size()), 32'h0);
    chk("t5_rx_data", 32'(bus_a.rx_data), 32'h1234);

    // Asynchronous reset in the middle of a frame
    tick(1);
    a_cs_n = 1'b0; #100;
    push_tx_a(16'h7777);
    bits_a(16'h9999, 9, mi);
    rst = 1'b1; #1;
    chk_reset_a("t6_rst");
    a_cs_n = 1'b1; #100;
    rst = 1'b0;
    tick(3);
    a_cs_n = 1'b0; #100;
    qa.push_back(16'hBEEF);
    bits_a(16'hBEEF, 16, mi);
    chk("t6_miso", 32'(mi), 32'hFFFF);
    #100 a_cs_n = 1'b1; #100;
    chk("t6_rx_seen", 32'(qa.size()), 32'h0);
    chk("end_qb_empty", 32'(qb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
